// File: rtl/point_tx_buffer.sv
// point_tx_buffer
//   Serialises a point list from a synchronous point RAM onto a UART line.
//   Frame: 8 x 0x00 sync, 4 bytes per point (flag, x/y bytes, MSB byte
//   first), then 4 x 0x01 terminator. Bytes are sent back-to-back, 8N1.
//
//   Optional feature macro: PT_TX_GAP_EN
//     Holds tx idle for GAP_BITS bit-times after the terminator before done.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   start    in   begin a frame (sampled only when idle)
//   num_pts  in   points to send, latched on an accepted start
//   index    out  point RAM read address
//   point    in   RAM read data, valid one cycle after index changes
//   tx       out  UART serial output, idles high
//   busy     out  frame in progress
//   done     out  one-cycle pulse when the frame is complete
module point_tx_buffer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BUFFER_SIZE  = 2000,
  parameter int GAP_BITS     = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [10:0] num_pts,
  output logic [10:0] index,
  input  logic [24:0] point,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int              BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [10:0]     N_MAX     = 11'(BUFFER_SIZE);
  localparam logic [7:0]      SYNC_BYTE = 8'h00;
  localparam logic [7:0]      TERM_BYTE = 8'h01;

`ifdef PT_TX_GAP_EN
  localparam int              GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int              GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_POINT,
    S_TERM,
`ifdef PT_TX_GAP_EN
    S_GAP,
`endif
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;   // 0 = start bit, 1..8 = data, 9 = stop
  logic [2:0]        byte_idx;  // byte position inside the current section
  logic [10:0]       k;         // point currently being sent
  logic [10:0]       n_pts;
  logic [7:0]        byte_sr;   // current byte, LSB shifted out first
  logic [23:0]       pt_data;   // coordinate bytes of the point being sent
  logic              baud_end;
  logic              byte_end;
  logic              sending;
  logic              last_pt;
  logic [7:0]        point_first;

`ifdef PT_TX_GAP_EN
  logic [GAP_W-1:0]  gap_cnt;
`endif

  assign baud_end    = (baud_cnt == BAUD_LAST);
  assign byte_end    = baud_end && (bit_cnt == 4'd9);
  assign sending     = (state == S_SYNC) || (state == S_POINT) || (state == S_TERM);
  assign last_pt     = (k == n_pts - 11'd1);
  // A flagged point starts with 0x3F, never 0x01, so it cannot mimic the terminator.
  assign point_first = point[24] ? 8'h3F : 8'h00;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SYNC;
      S_SYNC:  if (byte_end && byte_idx == 3'd7)
                 state_nx = (n_pts != '0) ? S_POINT : S_TERM;
      S_POINT: if (byte_end && byte_idx == 3'd3 && last_pt) state_nx = S_TERM;
      S_TERM:  if (byte_end && byte_idx == 3'd3) begin
`ifdef PT_TX_GAP_EN
                 state_nx = S_GAP;
`else
                 state_nx = S_DONE;
`endif
               end
`ifdef PT_TX_GAP_EN
      S_GAP:   if (gap_cnt == GAP_LAST) state_nx = S_DONE;
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx   = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_SYNC, S_POINT, S_TERM: begin
        busy = 1'b1;
        if (bit_cnt == 4'd0)      tx = 1'b0;
        else if (bit_cnt == 4'd9) tx = 1'b1;
        else                      tx = byte_sr[0];
      end
`ifdef PT_TX_GAP_EN
      S_GAP:   busy = 1'b1;
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Byte engine and point prefetch. The next byte is loaded in the last cycle
  // of the current stop bit so the following start bit begins with no gap.
  // index moves to k+1 as byte 3 starts; the RAM word for point k+1 is then
  // long settled when it is captured at the end of byte 3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      k        <= '0;
      n_pts    <= '0;
      index    <= '0;
      byte_sr  <= '0;
      pt_data  <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        n_pts    <= (num_pts > N_MAX) ? N_MAX : num_pts;
        index    <= '0;
        k        <= '0;
        byte_idx <= '0;
        bit_cnt  <= '0;
        baud_cnt <= '0;
        byte_sr  <= SYNC_BYTE;
      end
    end else if (sending) begin
      baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      if (baud_end) begin
        if (bit_cnt == 4'd9) begin
          bit_cnt  <= '0;
          byte_idx <= byte_idx + 3'd1;
          case (state)
            S_SYNC: begin
              if (byte_idx == 3'd7) begin
                byte_idx <= '0;
                if (n_pts != '0) begin
                  byte_sr <= point_first;
                  pt_data <= point[23:0];
                end else begin
                  byte_sr <= TERM_BYTE;
                end
              end else begin
                byte_sr <= SYNC_BYTE;
              end
            end
            S_POINT: begin
              case (byte_idx)
                3'd0: byte_sr <= pt_data[23:16];
                3'd1: byte_sr <= pt_data[15:8];
                3'd2: begin
                  byte_sr <= pt_data[7:0];
                  index   <= k + 11'd1;
                end
                default: begin
                  byte_idx <= '0;
                  if (last_pt) begin
                    byte_sr <= TERM_BYTE;
                  end else begin
                    k       <= k + 11'd1;
                    byte_sr <= point_first;
                    pt_data <= point[23:0];
                  end
                end
              endcase
            end
            default: begin
              byte_sr <= TERM_BYTE;
              if (byte_idx == 3'd3) byte_idx <= '0;
            end
          endcase
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt != 4'd0) byte_sr <= {1'b0, byte_sr[7:1]};
        end
      end
    end
  end

`ifdef PT_TX_GAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            gap_cnt <= '0;
    else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
    else                     gap_cnt <= '0;
  end
`endif

endmodule
